// File: rtl/red_pitaya_pid_pkg.sv
// ============================================================================
// Module   : red_pitaya_pid_pkg
// Brief    : Shared constants, register offsets and state encoding for the
//            PID output conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package red_pitaya_pid_pkg;

   localparam int DW_DEF   = 14;
   localparam int PREW_DEF = 16;
   localparam int CNTW_DEF = 16;

   localparam logic [19:0] ADDR_CTRL   = 20'h00;
   localparam logic [19:0] ADDR_STATUS = 20'h04;
   localparam logic [19:0] ADDR_LO_A   = 20'h10;
   localparam logic [19:0] ADDR_HI_A   = 20'h14;
   localparam logic [19:0] ADDR_STEP_A = 20'h18;
   localparam logic [19:0] ADDR_PRE_A  = 20'h1C;
   localparam logic [19:0] ADDR_CH_OFS = 20'h10;
   localparam logic [19:0] ADDR_CNT_A  = 20'h30;
   localparam logic [19:0] ADDR_CNT_B  = 20'h34;

   typedef enum logic [1:0] {
      ST_TRACK = 2'd0,
      ST_SLEW  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/red_pitaya_pid_outcond_if.sv
// ============================================================================
// Module   : red_pitaya_pid_outcond_if
// Brief    : System bus bundle used to reach the conditioner register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface red_pitaya_pid_outcond_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (
      output sys_addr, sys_wdata, sys_wen, sys_ren,
      input  sys_rdata, sys_err, sys_ack
   );

   modport slave (
      input  sys_addr, sys_wdata, sys_wen, sys_ren,
      output sys_rdata, sys_err, sys_ack
   );
endinterface

`default_nettype wire

// File: rtl/red_pitaya_outcond_ch.sv
// ============================================================================
// Module   : red_pitaya_outcond_ch
// Brief    : One conditioner channel: clamp, prescaled slew limiter, hold,
//            tracking state and clamp-event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_pitaya_outcond_ch
   import red_pitaya_pid_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int PREW = PREW_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic signed [DW-1:0] din,
   input  logic signed [DW-1:0] lo,
   input  logic signed [DW-1:0] hi,
   input  logic        [DW-1:0] step,
   input  logic      [PREW-1:0] pre,
   input  logic                 pre_wr,
   input  logic                 hold,
   input  logic                 clr,
   output logic signed [DW-1:0] dout,
   output state_t               state,
   output logic      [CNTW-1:0] cnt
);

   logic signed [DW-1:0] tgt;
   logic signed [DW-1:0] tgt_nxt;
   logic signed [DW-1:0] out_nxt;
   logic signed [DW-1:0] moved;
   logic signed [DW:0]   diff;
   logic        [DW:0]   mag;
   logic      [PREW-1:0] pcnt;
   logic                 tick;
   logic                 ev;

   always_comb begin
      ev = (din < lo) || (din > hi);
      // An inverted window collapses onto lo.
      if (lo > hi)
         tgt_nxt = lo;
      else if (din < lo)
         tgt_nxt = lo;
      else if (din > hi)
         tgt_nxt = hi;
      else
         tgt_nxt = din;
   end

   always_comb begin
      tick = (pcnt == pre);
      diff = {tgt[DW-1], tgt} - {dout[DW-1], dout};
      mag  = diff[DW] ? -diff : diff;
      // A full step never overshoots tgt, so DW-bit arithmetic cannot wrap.
      if (mag <= {1'b0, step})
         moved = tgt;
      else if (diff[DW])
         moved = dout - step;
      else
         moved = dout + step;

      if (hold)
         out_nxt = dout;
      else if (step == '0)
         out_nxt = tgt;
      else if (tick)
         out_nxt = moved;
      else
         out_nxt = dout;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tgt   <= '0;
         pcnt  <= '0;
         dout  <= '0;
         cnt   <= '0;
         state <= ST_TRACK;
      end else begin
         tgt  <= tgt_nxt;
         dout <= out_nxt;

         if (pre_wr || tick)
            pcnt <= '0;
         else
            pcnt <= pcnt + 1'b1;

         if (clr)
            cnt <= '0;
         else if (ev && !(&cnt))
            cnt <= cnt + 1'b1;

         if (hold)
            state <= ST_HOLD;
         else if (out_nxt == tgt_nxt)
            state <= ST_TRACK;
         else
            state <= ST_SLEW;
      end
   end

endmodule

`default_nettype wire

// File: rtl/red_pitaya_pid_outcond.sv
// ============================================================================
// Module   : red_pitaya_pid_outcond
// Brief    : Two-channel PID output conditioner with bus register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_pitaya_pid_outcond
   import red_pitaya_pid_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int PREW = PREW_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic signed [DW-1:0] dat_a_i,
   input  logic signed [DW-1:0] dat_b_i,
   output logic signed [DW-1:0] dat_a_o,
   output logic signed [DW-1:0] dat_b_o,
   red_pitaya_pid_outcond_if.slave sys
);

   logic signed [DW-1:0] lo   [2];
   logic signed [DW-1:0] hi   [2];
   logic        [DW-1:0] step [2];
   logic      [PREW-1:0] pre  [2];
   logic                 hold [2];
   logic signed [DW-1:0] din  [2];
   logic signed [DW-1:0] dout [2];
   state_t               st   [2];
   logic      [CNTW-1:0] cnt  [2];
   logic                 pre_wr [2];
   logic                 clr;
   logic        [19:0]   addr;
   logic        [31:0]   rd;
   logic                 unused_bits;

   assign addr        = sys.sys_addr[19:0];
   assign unused_bits = ^{sys.sys_addr[31:20], sys.sys_wdata[31:PREW]};
   assign sys.sys_err = 1'b0;
   assign din[0]      = dat_a_i;
   assign din[1]      = dat_b_i;
   assign dat_a_o     = dout[0];
   assign dat_b_o     = dout[1];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int c = 0; c < 2; c++) begin
            lo[c]   <= {1'b1, {(DW-1){1'b0}}};
            hi[c]   <= {1'b0, {(DW-1){1'b1}}};
            step[c] <= '0;
            pre[c]  <= '0;
            hold[c] <= 1'b0;
         end
         clr <= 1'b0;
      end else begin
         clr <= sys.sys_wen && (addr == ADDR_CTRL) && sys.sys_wdata[4];
         if (sys.sys_wen && (addr == ADDR_CTRL)) begin
            hold[0] <= sys.sys_wdata[0];
            hold[1] <= sys.sys_wdata[1];
         end
         for (int c = 0; c < 2; c++) begin
            if (sys.sys_wen && (addr == ADDR_LO_A + ADDR_CH_OFS * 20'(c)))
               lo[c] <= sys.sys_wdata[DW-1:0];
            if (sys.sys_wen && (addr == ADDR_HI_A + ADDR_CH_OFS * 20'(c)))
               hi[c] <= sys.sys_wdata[DW-1:0];
            if (sys.sys_wen && (addr == ADDR_STEP_A + ADDR_CH_OFS * 20'(c)))
               step[c] <= sys.sys_wdata[DW-1:0];
            if (sys.sys_wen && (addr == ADDR_PRE_A + ADDR_CH_OFS * 20'(c)))
               pre[c] <= sys.sys_wdata[PREW-1:0];
         end
      end
   end

   always_comb begin
      rd = '0;
      case (addr)
         ADDR_CTRL:   rd = {30'd0, hold[1], hold[0]};
         ADDR_STATUS: rd = {28'd0, st[1], st[0]};
         ADDR_LO_A:   rd = {{(32-DW){lo[0][DW-1]}}, lo[0]};
         ADDR_HI_A:   rd = {{(32-DW){hi[0][DW-1]}}, hi[0]};
         ADDR_STEP_A: rd = {{(32-DW){1'b0}}, step[0]};
         ADDR_PRE_A:  rd = {{(32-PREW){1'b0}}, pre[0]};
         ADDR_LO_A + ADDR_CH_OFS:   rd = {{(32-DW){lo[1][DW-1]}}, lo[1]};
         ADDR_HI_A + ADDR_CH_OFS:   rd = {{(32-DW){hi[1][DW-1]}}, hi[1]};
         ADDR_STEP_A + ADDR_CH_OFS: rd = {{(32-DW){1'b0}}, step[1]};
         ADDR_PRE_A + ADDR_CH_OFS:  rd = {{(32-PREW){1'b0}}, pre[1]};
         ADDR_CNT_A:  rd = {{(32-CNTW){1'b0}}, cnt[0]};
         ADDR_CNT_B:  rd = {{(32-CNTW){1'b0}}, cnt[1]};
         default:     rd = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sys.sys_ack   <= 1'b0;
         sys.sys_rdata <= '0;
      end else begin
         sys.sys_ack <= sys.sys_wen | sys.sys_ren;
         if (sys.sys_ren)
            sys.sys_rdata <= rd;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_ch
      assign pre_wr[g] = sys.sys_wen && (addr == ADDR_PRE_A + ADDR_CH_OFS * 20'(g));

      red_pitaya_outcond_ch #(
         .DW   (DW),
         .PREW (PREW),
         .CNTW (CNTW)
      ) u_ch (
         .clk    (clk_i),
         .rstn   (rstn_i),
         .din    (din[g]),
         .lo     (lo[g]),
         .hi     (hi[g]),
         .step   (step[g]),
         .pre    (pre[g]),
         .pre_wr (pre_wr[g]),
         .hold   (hold[g]),
         .clr    (clr),
         .dout   (dout[g]),
         .state  (st[g]),
         .cnt    (cnt[g])
      );
   end

endmodule

`default_nettype wire
